// File: rtl/issue_scoreboard_pkg.sv
// Shared constants, request structs and hazard helper for the issue scoreboard.
package issue_scoreboard_pkg;
  localparam int LAT_W = 3;
  localparam int NREG  = 32;
  localparam int REG_W = 5;

  localparam logic [LAT_W-1:0] LAT_NONE = '0;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_MUL  = LAT_W'(3);
  localparam logic [LAT_W-1:0] LAT_INF  = '1;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             fire;
    logic             dst_en;
    logic [REG_W-1:0] dst;
    logic [LAT_W-1:0] lat;
  } wr_req_t;

  typedef struct packed {
    logic             rs_en;
    logic [REG_W-1:0] rs;
    logic             rt_en;
    logic [REG_W-1:0] rt;
  } src_req_t;

  function automatic logic src_hit(input logic en, input logic [REG_W-1:0] a,
                                   input logic [NREG-1:0] busy);
    return en && (a != REG_ZERO) && busy[a];
  endfunction
endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-stage <-> scoreboard bundle: write records, source queries, hazards.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;
  logic             flush;
  logic             stall_in;
  wr_req_t          first_wr;
  wr_req_t          second_wr;
  src_req_t         first_src;
  src_req_t         second_src;
  logic             first_valid;
  logic             long_done_en;
  logic [REG_W-1:0] long_done_addr;
  logic             first_hazard;
  logic             second_hazard;
  logic [NREG-1:0]  busy_vec;

  modport master (
    output flush, stall_in, first_wr, second_wr, first_src, second_src,
           first_valid, long_done_en, long_done_addr,
    input  first_hazard, second_hazard, busy_vec
  );
  modport slave (
    input  flush, stall_in, first_wr, second_wr, first_src, second_src,
           first_valid, long_done_en, long_done_addr,
    output first_hazard, second_hazard, busy_vec
  );
endinterface

// File: rtl/issue_scoreboard_entry.sv
// One GPR countdown: cycles remaining before its pending write is forwardable.
module issue_scoreboard_entry
  import issue_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             stall,
  input  logic             wr_second,
  input  logic [LAT_W-1:0] lat_second,
  input  logic             wr_first,
  input  logic [LAT_W-1:0] lat_first,
  input  logic             done,
  output logic [LAT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!resetn || flush) cnt <= LAT_NONE;
    else if (!stall) begin
      // younger slot wins a same-destination pair; a new issue beats long_done
      if (wr_second)                                  cnt <= lat_second;
      else if (wr_first)                              cnt <= lat_first;
      else if (done && cnt == LAT_INF)                cnt <= LAT_NONE;
      else if (cnt != LAT_NONE && cnt != LAT_INF)     cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/issue_scoreboard.sv
// Per-GPR forwardability scoreboard; raises issue hazards for the dual-issue pair.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  issue_scoreboard_if.slave  sb
);
  logic [NREG-1:0][LAT_W-1:0] cnt;
  logic [NREG-1:0]            busy;

  assign cnt[0] = LAT_NONE;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    issue_scoreboard_entry u_ent (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (sb.flush),
      .stall      (sb.stall_in),
      .wr_second  (sb.second_wr.fire && sb.second_wr.dst_en && (sb.second_wr.dst == REG_W'(r))),
      .lat_second (sb.second_wr.lat),
      .wr_first   (sb.first_wr.fire && sb.first_wr.dst_en && (sb.first_wr.dst == REG_W'(r))),
      .lat_first  (sb.first_wr.lat),
      .done       (sb.long_done_en && (sb.long_done_addr == REG_W'(r))),
      .cnt        (cnt[r])
    );
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) busy[r] = |cnt[r];
  end

  logic first_h, pair_dep;

  // hazards depend on cnt and source/dst fields only, never on *_fire
  always_comb begin
    first_h  = src_hit(sb.first_src.rs_en, sb.first_src.rs, busy) |
               src_hit(sb.first_src.rt_en, sb.first_src.rt, busy);
    pair_dep = sb.first_valid && sb.first_wr.dst_en && (sb.first_wr.dst != REG_ZERO) &&
               ((sb.second_src.rs_en && sb.second_src.rs == sb.first_wr.dst) ||
                (sb.second_src.rt_en && sb.second_src.rt == sb.first_wr.dst));
  end

  assign sb.busy_vec      = busy;
  assign sb.first_hazard  = first_h;
  assign sb.second_hazard = first_h | pair_dep |
                            src_hit(sb.second_src.rs_en, sb.second_src.rs, busy) |
                            src_hit(sb.second_src.rt_en, sb.second_src.rt, busy);
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench with a cycle-level readiness model of the register file.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  issue_scoreboard_if bus();
  issue_scoreboard dut (.clk(clk), .resetn(resetn), .sb(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: remaining non-forwardable cycles per register, -1 = until long_done.
  int m_rem [NREG];
  initial for (int r = 0; r < NREG; r++) m_rem[r] = 0;

  function automatic int to_rem(input logic [LAT_W-1:0] lat);
    return (lat == LAT_INF) ? -1 : int'(lat);
  endfunction

  always @(posedge clk) begin
    if (!resetn || bus.flush) begin
      for (int r = 0; r < NREG; r++) m_rem[r] = 0;
    end else if (!bus.stall_in) begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.second_wr.fire && bus.second_wr.dst_en && bus.second_wr.dst == r)
          m_rem[r] = to_rem(bus.second_wr.lat);
        else if (bus.first_wr.fire && bus.first_wr.dst_en && bus.first_wr.dst == r)
          m_rem[r] = to_rem(bus.first_wr.lat);
        else if (m_rem[r] == -1)
          m_rem[r] = (bus.long_done_en && bus.long_done_addr == r) ? 0 : -1;
        else if (m_rem[r] > 0)
          m_rem[r] = m_rem[r] - 1;
      end
    end
  end

  function automatic bit m_busy(input logic en, input logic [4:0] a);
    return en && a != 0 && m_rem[a] != 0;
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      logic [31:0] exp_busy;
      bit e1, e2;
      exp_busy = '0;
      for (int r = 1; r < NREG; r++) exp_busy[r] = (m_rem[r] != 0);
      e1 = m_busy(bus.first_src.rs_en, bus.first_src.rs) || m_busy(bus.first_src.rt_en, bus.first_src.rt);
      e2 = e1 || m_busy(bus.second_src.rs_en, bus.second_src.rs) ||
           m_busy(bus.second_src.rt_en, bus.second_src.rt) ||
           (bus.first_valid && bus.first_wr.dst_en && bus.first_wr.dst != 0 &&
            ((bus.second_src.rs_en && bus.second_src.rs == bus.first_wr.dst) ||
             (bus.second_src.rt_en && bus.second_src.rt == bus.first_wr.dst)));
      chk("model_busy_vec", bus.busy_vec, exp_busy);
      chk("model_first_hazard", 32'(bus.first_hazard), 32'(e1));
      chk("model_second_hazard", 32'(bus.second_hazard), 32'(e2));
    end
  end

  task automatic clr();
    bus.flush = 0; bus.stall_in = 0; bus.first_valid = 0;
    bus.first_wr = '0; bus.second_wr = '0; bus.first_src = '0; bus.second_src = '0;
    bus.long_done_en = 0; bus.long_done_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fire1(input logic [4:0] d, input logic [LAT_W-1:0] l);
    bus.first_wr = '{fire: 1'b1, dst_en: 1'b1, dst: d, lat: l};
  endtask

  task automatic fire2(input logic [4:0] d, input logic [LAT_W-1:0] l);
    bus.second_wr = '{fire: 1'b1, dst_en: 1'b1, dst: d, lat: l};
  endtask

  initial begin
    clr();
    // T1: reset edge with fires pending
    resetn = 0;
    fire1(5'd3, 3'd2); fire2(5'd4, LAT_INF);
    tick();
    clr();
    bus.first_src = '{rs_en: 1'b1, rs: 5'd3, rt_en: 1'b1, rt: 5'd4};
    @(negedge clk);
    chk("t1_busy_vec", bus.busy_vec, 32'h0);
    chk("t1_first_hazard", 32'(bus.first_hazard), 32'd0);
    chk("t1_second_hazard", 32'(bus.second_hazard), 32'd0);
    model_on = 1'b1;
    resetn = 1; clr();
    tick();

    // T2: load-use, one-cycle hazard
    fire1(5'd8, LAT_LOAD);
    tick(); clr();
    bus.second_src = '{rs_en: 1'b1, rs: 5'd8, rt_en: 1'b0, rt: 5'd0};
    @(negedge clk);
    chk("t2_second_hazard_on", 32'(bus.second_hazard), 32'd1);
    chk("t2_first_hazard", 32'(bus.first_hazard), 32'd0);
    tick();
    @(negedge clk);
    chk("t2_second_hazard_off", 32'(bus.second_hazard), 32'd0);
    tick(); clr();

    // T3: divide held until long_done
    fire1(5'd5, LAT_INF);
    tick(); clr();
    bus.first_src = '{rs_en: 1'b1, rs: 5'd5, rt_en: 1'b0, rt: 5'd0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_div_hold", 32'(bus.first_hazard), 32'd1);
      tick();
    end
    bus.long_done_en = 1; bus.long_done_addr = 5'd5;
    @(negedge clk);
    chk("t3_done_cycle", 32'(bus.first_hazard), 32'd1);
    tick();
    bus.long_done_en = 0;
    @(negedge clk);
    chk("t3_after_done", 32'(bus.first_hazard), 32'd0);
    tick(); clr();

    // long_done to a finite-latency register is ignored
    fire1(5'd10, LAT_MUL);
    tick(); clr();
    bus.long_done_en = 1; bus.long_done_addr = 5'd10;
    tick(); clr();
    @(negedge clk);
    chk("done_non_inf_ignored", 32'(bus.busy_vec[10]), 32'd1);
    tick(); tick();

    // T4: same-dst pair, younger latency wins
    fire1(5'd9, LAT_LOAD); fire2(5'd9, 3'd3);
    tick(); clr();
    bus.first_src = '{rs_en: 1'b0, rs: 5'd0, rt_en: 1'b1, rt: 5'd9};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_pair_hazard", 32'(bus.first_hazard), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("t4_pair_clear", 32'(bus.first_hazard), 32'd0);
    tick(); clr();

    // T5: stall holds, flush clears (even over a same-cycle fire)
    fire1(5'd4, LAT_MUL);
    tick(); clr();
    bus.stall_in = 1;
    repeat (4) tick();
    @(negedge clk);
    chk("t5_stall_busy", bus.busy_vec, 32'h0000_0010);
    bus.stall_in = 0;
    tick();
    @(negedge clk);
    chk("t5_after_one", bus.busy_vec, 32'h0000_0010);
    bus.flush = 1; fire1(5'd6, 3'd2); fire2(5'd7, LAT_INF);
    tick(); clr();
    @(negedge clk);
    chk("t5_flush", bus.busy_vec, 32'h0);
    tick();

    // dst 0 is never recorded
    fire1(5'd0, LAT_MUL); fire2(5'd0, LAT_INF);
    tick(); clr();
    bus.first_src = '{rs_en: 1'b1, rs: 5'd0, rt_en: 1'b0, rt: 5'd0};
    @(negedge clk);
    chk("r0_busy_vec", bus.busy_vec, 32'h0);
    chk("r0_hazard", 32'(bus.first_hazard), 32'd0);
    tick(); clr();

    // T6: intra-pair dependence with empty scoreboard
    bus.first_valid = 1;
    bus.first_wr = '{fire: 1'b0, dst_en: 1'b1, dst: 5'd7, lat: LAT_NONE};
    bus.second_src = '{rs_en: 1'b0, rs: 5'd0, rt_en: 1'b1, rt: 5'd7};
    @(negedge clk);
    chk("t6_first_hazard", 32'(bus.first_hazard), 32'd0);
    chk("t6_second_hazard", 32'(bus.second_hazard), 32'd1);
    tick();
    bus.first_wr.dst = 5'd0;
    bus.second_src.rt = 5'd0;
    @(negedge clk);
    chk("t6_dst0", 32'(bus.second_hazard), 32'd0);
    tick();
    bus.first_wr.dst = 5'd7; bus.second_src.rt = 5'd7; bus.first_valid = 0;
    @(negedge clk);
    chk("t6_invalid_first", 32'(bus.second_hazard), 32'd0);
    tick(); clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
